bcd_display_scan: RTL and testbench
===================================

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 Parameter Ndigit, default 4: number of BCD digits displayed, range 1..8.
REQ-002 Parameter SCAN_MAX, default 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz), minimum 2.
REQ-003 Port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port en, input, 1: scan enable; when low, scanning freezes and the display blanks.
REQ-006 Port BCD, input, 4*Ndigit: packed BCD value; BCD[4k+3:4k] is digit k, digit 0 least significant.
REQ-007 Port anode, output, Ndigit: digit select, active-low, one-hot-low when a digit is lit.
REQ-008 Port seg, output, 7: segment drive {g,f,e,d,c,b,a}, active-low.
REQ-009 Port dp, output, 1: decimal point, active-low, always 1 (off) in this revision.

Function
REQ-010 Prescaler counts 0..SCAN_MAX-1 while en=1, wraps to 0, holds while en=0; tick = en AND prescaler==SCAN_MAX-1.
REQ-011 Digit index counts 0..Ndigit-1 and advances by 1 on each tick, wrapping from Ndigit-1 to 0.
REQ-012 Snapshot register (4*Ndigit) loads BCD only on a tick with index==Ndigit-1 (frame wrap); BCD changes mid-frame never reach the display before the next frame.
REQ-013 anode, seg, dp are registered; each reflects the index and snapshot of the previous cycle (1-cycle latency).
REQ-014 With en=1: anode[index]=0, all other anode bits=1; seg = the decode of snapshot digit[index].
REQ-015 Decode, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-016 Invalid codes 4'hA..4'hF decode to a dash, seg=0111111.
REQ-017 With en=0: anode=all ones, seg=1111111; prescaler, index and snapshot hold; re-enabling resumes on the same digit with the prescaler value retained.
REQ-018 Ndigit=1: index stays 0; the snapshot loads on every tick.

Reset
REQ-019 While rst=1 at a clock edge: prescaler=0, index=0, snapshot=0, anode=all ones, seg=1111111, dp=1.
REQ-020 At the first edge after release, with en=1, outputs show digit 0 of the zero snapshot (anode=...1110, seg=1000000); the first real BCD value appears after the first frame wrap.
REQ-021 Reset asserted mid-operation overrides en and ticks, and returns all state to REQ-019 values at that edge.

Configuration
REQ-022 Macro LEADING_ZERO_BLANK_EN, when defined: any digit k>0 with snapshot digits k..Ndigit-1 all zero is blanked (its anode bit stays 1, seg=1111111 during its slot); digit 0 is never blanked; slot timing is unchanged.
REQ-023 LEADING_ZERO_BLANK_EN not defined: all Ndigit digits are always lit in turn, including leading zeros.

Verification (Ndigit=4, SCAN_MAX=4, 100 MHz clock)
REQ-024 Hold rst=1 for 5 cycles, then release with en=1 -> anode=1111/seg=1111111 during reset; first edge after release gives anode=1110, seg=1000000.
REQ-025 BCD=16'h1234 applied after reset -> after 16 cycles the snapshot loads; anode cycles 1110,1101,1011,0111 every 4 cycles with seg 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
REQ-026 Change BCD from 16'h1234 to 16'h5678 mid-frame -> remaining slots of the current frame still show 1234; the next frame shows 8,7,6,5.
REQ-027 BCD=16'h00A9 -> digit 1 slot shows seg=0111111 (dash); digit 0 shows 0010000 (9).
REQ-028 Drop en for 10 cycles during digit-2 slot -> anode=1111, seg=1111111 one cycle later; after en returns, digit 2 is shown again and completes its remaining slot cycles.
REQ-029 With LEADING_ZERO_BLANK_EN defined, BCD=16'h0050 -> digit 2 and 3 slots keep anode=1111; BCD=16'h0000 -> only digit 0 is lit, showing 1000000; with the macro undefined, all four slots are lit.

Source files
------------

// File: rtl/bcd_display_scan.sv
// Multiplexed BCD seven-segment display scanner.
// One digit is lit per slot of SCAN_MAX cycles; the BCD value is captured
// once per frame so a frame never mixes two input values.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
`timescale 1ns/1ps

module bcd_display_scan #(
    parameter int unsigned Ndigit   = 4,
    parameter int unsigned SCAN_MAX = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*Ndigit-1:0]   BCD,
    output logic [Ndigit-1:0]     anode,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int unsigned PW = $clog2(SCAN_MAX);
    localparam int unsigned IW = (Ndigit > 1) ? $clog2(Ndigit) : 1;
    localparam int unsigned BW = 4 * Ndigit;
    localparam logic [6:0]  SEG_OFF = 7'b1111111;

    logic [PW-1:0]      r_presc;
    logic [IW-1:0]      r_idx;
    logic [BW-1:0]      r_snap;
    logic [Ndigit-1:0]  r_anode;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_tick;
    logic               w_wrap;
    logic [3:0]         w_digit;
    logic [Ndigit-1:0]  w_anode;
    logic [6:0]         w_seg;
    logic [Ndigit-1:0]  w_blank;
    logic               w_lit;

    assign w_tick = en && (r_presc == PW'(SCAN_MAX - 1));
    assign w_wrap = (r_idx == IW'(Ndigit - 1));

    // Slot prescaler, digit index and per-frame BCD snapshot; all hold while en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_snap  <= '0;
        end else if (en) begin
            if (w_tick) begin
                r_presc <= '0;
                if (w_wrap) begin
                    r_idx  <= '0;
                    r_snap <= BCD;
                end else begin
                    r_idx  <= r_idx + IW'(1);
                end
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // Select the active digit nibble and its active-low anode pattern.
    always_comb begin
        w_digit = 4'h0;
        w_anode = '1;
        for (int k = 0; k < int'(Ndigit); k++) begin
            if (r_idx == IW'(k)) begin
                w_digit    = r_snap[4*k +: 4];
                w_anode[k] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k>0 is blanked when it and every more significant digit are zero.
    always_comb begin
        logic v_all_zero;
        v_all_zero = 1'b1;
        w_blank    = '0;
        for (int k = int'(Ndigit) - 1; k > 0; k--) begin
            v_all_zero = v_all_zero && (r_snap[4*k +: 4] == 4'h0);
            w_blank[k] = v_all_zero;
        end
    end
`else
    assign w_blank = '0;
`endif

    assign w_lit = ~|(w_blank & ~w_anode);

    // BCD to active-low gfedcba; non-decimal codes show a dash.
    always_comb begin
        w_seg = 7'b0111111;
        case (w_digit)
            4'd0: w_seg = 7'b1000000;
            4'd1: w_seg = 7'b1111001;
            4'd2: w_seg = 7'b0100100;
            4'd3: w_seg = 7'b0110000;
            4'd4: w_seg = 7'b0011001;
            4'd5: w_seg = 7'b0010010;
            4'd6: w_seg = 7'b0000010;
            4'd7: w_seg = 7'b1111000;
            4'd8: w_seg = 7'b0000000;
            4'd9: w_seg = 7'b0010000;
            default: w_seg = 7'b0111111;
        endcase
    end

    // Registered display drive; blank during reset, while disabled, or on a blanked digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_anode <= '1;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
        end else if (en && w_lit) begin
            r_anode <= w_anode;
            r_seg   <= w_seg;
            r_dp    <= 1'b1;
        end else begin
            r_anode <= '1;
            r_seg   <= SEG_OFF;
            r_dp    <= 1'b1;
        end
    end

    assign anode = r_anode;
    assign seg   = r_seg;
    assign dp    = r_dp;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with Ndigit=4, SCAN_MAX=4.
`timescale 1ns/1ps

module tb_bcd_display_scan;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] BCD;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;

    int n_vec;
    int n_err;

    bcd_display_scan #(.Ndigit(4), .SCAN_MAX(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .BCD   (BCD),
        .anode (anode),
        .seg   (seg),
        .dp    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One edge: expect the given anode/seg pattern (dp always off).
    task automatic check_out(input string tag, input logic [3:0] ea, input logic [6:0] es);
        check_eq({tag, "_an"},  16'(anode), 16'(ea));
        check_eq({tag, "_seg"}, 16'(seg),   16'(es));
        check_eq({tag, "_dp"},  16'(dp),    16'(1'b1));
    endtask

    function automatic logic [3:0] an_of(input int k, input bit blank);
        logic [3:0] one;
        one = 4'b0001;
        return blank ? 4'hF : ~(one << k);
    endfunction

    // Full 4-cycle slot of digit k.
    task automatic run_slot(input string tag, input int k, input logic [6:0] dseg, input bit blank);
        for (int c = 0; c < 4; c++) begin
            step();
            check_out($sformatf("%s_c%0d", tag, c), an_of(k, blank), blank ? SB : dseg);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        en    = 1'b1;
        BCD   = 16'h1234;

        // Reset held for 5 edges.
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("rst%0d", i), 4'hF, SB);
        end
        rst = 1'b0;

        // Frame 0: zero snapshot.
        run_slot("f0d0", 0, S0, 1'b0);
        run_slot("f0d1", 1, S0, LZB);
        run_slot("f0d2", 2, S0, LZB);
        run_slot("f0d3", 3, S0, LZB);

        // Frame 1: 1234; input changes mid-frame without effect.
        run_slot("f1d0", 0, S4, 1'b0);
        BCD = 16'h5678;
        run_slot("f1d1", 1, S3, 1'b0);
        run_slot("f1d2", 2, S2, 1'b0);
        run_slot("f1d3", 3, S1, 1'b0);

        // Frame 2: 5678.
        run_slot("f2d0", 0, S8, 1'b0);
        BCD = 16'h00A9;
        run_slot("f2d1", 1, S7, 1'b0);
        run_slot("f2d2", 2, S6, 1'b0);
        run_slot("f2d3", 3, S5, 1'b0);

        // Frame 3: 00A9 -> 9, dash, 0, 0.
        run_slot("f3d0", 0, S9, 1'b0);
        run_slot("f3d1", 1, SD, 1'b0);
        run_slot("f3d2", 2, S0, LZB);
        run_slot("f3d3", 3, S0, LZB);

        // Frame 4: enable dropped for 10 cycles inside the digit-2 slot.
        run_slot("f4d0", 0, S9, 1'b0);
        run_slot("f4d1", 1, SD, 1'b0);
        step();
        check_out("f4d2_pre", an_of(2, LZB), LZB ? SB : S0);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_out($sformatf("en_off%0d", i), 4'hF, SB);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("f4d2_post%0d", i), an_of(2, LZB), LZB ? SB : S0);
        end
        run_slot("f4d3", 3, S0, LZB);

        // Frame 5: reset mid-slot returns to the zero snapshot.
        step();
        check_out("f5d0_a", 4'b1110, S9);
        step();
        check_out("f5d0_b", 4'b1110, S9);
        rst = 1'b1;
        step();
        check_out("midrst", 4'hF, SB);
        rst = 1'b0;
        BCD = 16'h0050;
        run_slot("r0d0", 0, S0, 1'b0);
        run_slot("r0d1", 1, S0, LZB);
        run_slot("r0d2", 2, S0, LZB);
        run_slot("r0d3", 3, S0, LZB);

        // 0050 frame.
        run_slot("z1d0", 0, S0, 1'b0);
        BCD = 16'h0000;
        run_slot("z1d1", 1, S5, 1'b0);
        run_slot("z1d2", 2, S0, LZB);
        run_slot("z1d3", 3, S0, LZB);

        // All-zero frame.
        run_slot("z2d0", 0, S0, 1'b0);
        run_slot("z2d1", 1, S0, LZB);
        run_slot("z2d2", 2, S0, LZB);
        run_slot("z2d3", 3, S0, LZB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
